// File: rtl/cpu_pkg.sv
// Shared encodings for the boot loader: loader and UART receiver states plus line constants.
package cpu_pkg;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } loader_state_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_START = 2'd1,
        R_DATA  = 2'd2,
        R_STOP  = 2'd3
    } rx_state_e;

    localparam logic     UART_IDLE      = 1'b1;
    localparam int       UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser, start-bit glitch rejection, centre sampling,
// one-cycle byte_valid / framing_err pulses.
module uart_rx_byte
    import cpu_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       byte_valid_o,
    output logic       framing_err_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int HALF  = CLKS_PER_BIT / 2;

    logic             sync1_q;
    logic             sync2_q;
    logic             prev_q;
    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_q;
    logic             byte_valid_q;
    logic             framing_err_q;

    // Synchroniser, bit timer and frame sequencing; a frame only starts on a high-to-low edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q       <= UART_IDLE;
            sync2_q       <= UART_IDLE;
            prev_q        <= UART_IDLE;
            state_q       <= R_IDLE;
            cnt_q         <= '0;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'd0;
            data_q        <= 8'd0;
            byte_valid_q  <= 1'b0;
            framing_err_q <= 1'b0;
        end else begin
            sync1_q       <= rx_i;
            sync2_q       <= sync1_q;
            prev_q        <= sync2_q;
            byte_valid_q  <= 1'b0;
            framing_err_q <= 1'b0;
            case (state_q)
                R_IDLE: begin
                    cnt_q <= '0;
                    if (prev_q == UART_IDLE && sync2_q != UART_IDLE) begin
                        state_q <= R_START;
                    end
                end
                R_START: begin
                    if (cnt_q == CNT_W'(HALF - 1)) begin
                        cnt_q <= '0;
                        if (sync2_q == UART_IDLE) begin
                            state_q <= R_IDLE;
                        end else begin
                            state_q   <= R_DATA;
                            bit_cnt_q <= 3'd0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                R_DATA: begin
                    if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt_q   <= '0;
                        shift_q <= {sync2_q, shift_q[7:1]};
                        if (bit_cnt_q == 3'(UART_DATA_BITS - 1)) begin
                            state_q <= R_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                R_STOP: begin
                    if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt_q   <= '0;
                        state_q <= R_IDLE;
                        if (sync2_q == UART_IDLE) begin
                            data_q       <= shift_q;
                            byte_valid_q <= 1'b1;
                        end else begin
                            framing_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= R_IDLE;
            endcase
        end
    end

    assign data_o        = data_q;
    assign byte_valid_o  = byte_valid_q;
    assign framing_err_o = framing_err_q;

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: packs UART bytes little-endian into words, writes CELL_NUMBERS words to
// instruction memory, then releases the CPU from reset.
module uart_imem_loader
    import cpu_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int CELL_NUMBERS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        load_done,
    output logic        cpu_hold,
    output logic        framing_err
);

    localparam int          IDX_RAW = $clog2(CELL_NUMBERS + 1);
    localparam int          IDX_W   = (IDX_RAW < 1) ? 1 : IDX_RAW;
    localparam logic [31:0] CELLS   = 32'(CELL_NUMBERS);

    logic [7:0]       rx_data_s;
    logic             byte_valid_s;
    logic             framing_err_s;
    logic [31:0]      idx_ext_s;

    loader_state_e    state_q;
    logic [1:0]       lane_q;
    logic [31:0]      word_q;
    logic [IDX_W-1:0] word_idx_q;
    logic             mem_we_q;
    logic [31:0]      mem_addr_q;
    logic [31:0]      mem_wdata_q;
    logic             load_done_q;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_i        (clk),
        .rst_i        (rst),
        .rx_i         (uart_rx),
        .data_o       (rx_data_s),
        .byte_valid_o (byte_valid_s),
        .framing_err_o(framing_err_s)
    );

    assign idx_ext_s = 32'(word_idx_q);

    // Loader FSM; the 4th byte registers the write so mem_we appears the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_LOAD;
            lane_q      <= 2'd0;
            word_q      <= 32'd0;
            word_idx_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            load_done_q <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (CELLS == 32'd0) begin
                        state_q     <= S_DONE;
                        load_done_q <= 1'b1;
                    end else if (byte_valid_s) begin
                        word_q[8*lane_q +: 8] <= rx_data_s;
                        if (lane_q == 2'd3) begin
                            lane_q      <= 2'd0;
                            state_q     <= S_WRITE;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= {idx_ext_s[29:0], 2'b00};
                            mem_wdata_q <= {rx_data_s, word_q[23:0]};
                        end else begin
                            lane_q <= lane_q + 2'd1;
                        end
                    end else begin
                        lane_q <= lane_q;
                    end
                end
                S_WRITE: begin
                    mem_we_q   <= 1'b0;
                    word_idx_q <= word_idx_q + IDX_W'(1);
                    if (byte_valid_s) begin
                        word_q[7:0] <= rx_data_s;
                        lane_q      <= 2'd1;
                    end else begin
                        lane_q <= 2'd0;
                    end
                    if (idx_ext_s + 32'd1 == CELLS) begin
                        state_q     <= S_DONE;
                        load_done_q <= 1'b1;
                    end else begin
                        state_q <= S_LOAD;
                    end
                end
                S_DONE: begin
                    mem_we_q    <= 1'b0;
                    load_done_q <= 1'b1;
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign load_done   = load_done_q;
    assign cpu_hold    = ~load_done_q;
    assign framing_err = framing_err_s;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed bench for uart_imem_loader with a write scoreboard (CLKS_PER_BIT=16, CELL_NUMBERS=2).
module tb_uart_imem_loader;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rx = 1'b1;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        load_done;
    logic        cpu_hold;
    logic        framing_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int we_cnt = 0;
    int we_cyc = 0;
    int done_cyc = 0;
    bit done_seen = 1'b0;
    int fe_cnt = 0;
    int fe_run = 0;
    int fe_max = 0;
    int hold_bad = 0;
    logic [63:0] sb[$];

    uart_imem_loader #(
        .CLKS_PER_BIT(CPB),
        .CELL_NUMBERS(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .load_done  (load_done),
        .cpu_hold   (cpu_hold),
        .framing_err(framing_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard and pulse monitors, sampled on the falling edge.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && mem_we === 1'b1) begin
            we_cnt++;
            we_cyc = cyc;
            check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("mem_addr", mem_addr, e[63:32]);
                check("mem_wdata", mem_wdata, e[31:0]);
            end
        end
        if (load_done === 1'b1 && !done_seen) begin
            done_seen = 1'b1;
            done_cyc = cyc;
        end
        if (framing_err === 1'b1) begin
            fe_run++;
            if (fe_run == 1) fe_cnt++;
            if (fe_run > fe_max) fe_max = fe_run;
        end else begin
            fe_run = 0;
        end
        if (cpu_hold !== ~load_done) hold_bad++;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(posedge clk);
        uart_rx = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic pulse_reset(input int n);
        @(posedge clk);
        rst = 1'b1;
        #1;
        check("cpu_hold_in_rst", 32'(cpu_hold), 32'd1);
        check("load_done_in_rst", 32'(load_done), 32'd0);
        check("mem_we_in_rst", 32'(mem_we), 32'd0);
        repeat (n) @(posedge clk);
        uart_rx = 1'b1;
        rst = 1'b0;
        done_seen = 1'b0;
    endtask

    initial begin
        // 1: reset then long idle
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        repeat (200) @(posedge clk);
        @(negedge clk);
        check("idle_we_cnt", 32'(we_cnt), 32'd0);
        check("idle_load_done", 32'(load_done), 32'd0);
        check("idle_cpu_hold", 32'(cpu_hold), 32'd1);

        // 2: first word
        sb.push_back({32'h0000_0000, 32'h0020_0113});
        send_byte(8'h13, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h20, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("w0_we_cnt", 32'(we_cnt), 32'd1);
        check("w0_load_done", 32'(load_done), 32'd0);
        check("w0_cpu_hold", 32'(cpu_hold), 32'd1);

        // 3: second (last) word, then ignored traffic
        sb.push_back({32'h0000_0004, 32'h0000_A103});
        send_byte(8'h03, 1'b1);
        send_byte(8'hA1, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("w1_we_cnt", 32'(we_cnt), 32'd2);
        check("done_seen", 32'(done_seen), 32'd1);
        check("done_latency", 32'(done_cyc), 32'(we_cyc + 1));
        check("done_cpu_hold", 32'(cpu_hold), 32'd0);
        send_byte(8'hFF, 1'b1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("post_we_cnt", 32'(we_cnt), 32'd2);
        check("post_load_done", 32'(load_done), 32'd1);
        check("post_addr_hold", mem_addr, 32'h0000_0004);
        check("post_wdata_hold", mem_wdata, 32'h0000_A103);

        // 4: framing error then a clean word
        pulse_reset(5);
        send_byte(8'h55, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("fe_cnt", 32'(fe_cnt), 32'd1);
        check("fe_width", 32'(fe_max), 32'd1);
        check("fe_no_we", 32'(we_cnt), 32'd2);
        sb.push_back({32'h0000_0000, 32'h0020_0113});
        send_byte(8'h13, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h20, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("fe_w_we_cnt", 32'(we_cnt), 32'd3);
        check("fe_w_load_done", 32'(load_done), 32'd0);

        // 5: reset in the middle of the third frame
        send_byte(8'h13, 1'b1);
        send_byte(8'h01, 1'b1);
        uart_rx = 1'b0;
        repeat (3 * CPB) @(posedge clk);
        pulse_reset(3);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("midrst_we_cnt", 32'(we_cnt), 32'd3);
        sb.push_back({32'h0000_0000, 32'hDDCC_BBAA});
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        send_byte(8'hDD, 1'b1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("midrst_w_we_cnt", 32'(we_cnt), 32'd4);
        check("midrst_load_done", 32'(load_done), 32'd0);

        // 6: short low glitch must not start a frame
        uart_rx = 1'b0;
        repeat (4) @(posedge clk);
        uart_rx = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("glitch_fe_cnt", 32'(fe_cnt), 32'd1);
        sb.push_back({32'h0000_0004, 32'h0020_0113});
        send_byte(8'h13, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h20, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("glitch_we_cnt", 32'(we_cnt), 32'd5);
        check("glitch_load_done", 32'(load_done), 32'd1);
        check("glitch_cpu_hold", 32'(cpu_hold), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("hold_tracks_done", 32'(hold_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
